// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding, parity constants.
package fifo_uart_tx_pkg;

    localparam int unsigned PRESCALE_W = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // A prescale of zero is treated as one cycle per bit.
    function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] p);
        return (p == '0) ? PRESCALE_W'(1) : p;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bitcnt.sv
// Prescale counter and data-bit index for the UART transmitter.
module fifo_uart_tx_bitcnt
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  data_phase,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_end_c,
    output logic                  last_data_c
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;

    // Flag the last cycle of a bit and the last data bit; compute next counter values.
    always_comb begin
        bit_end_c   = (pre_cnt_q == (eff_prescale(prescale) - PRESCALE_W'(1)));
        last_data_c = (bit_idx_q == IDX_W'(DATA_WIDTH - 1));

        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
        if (!run || bit_end_c) begin
            pre_cnt_d = '0;
        end

        bit_idx_d = bit_idx_q;
        if (!data_phase) begin
            bit_idx_d = '0;
        end else if (bit_end_c) begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
            bit_idx_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            bit_idx_q <= bit_idx_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FIFO read port and sends them back-to-back.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  EMPTY,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  R_INC,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tx_q, tx_d;
    logic                  r_inc_q, r_inc_d;
    logic                  busy_q, busy_d;
    logic                  load;
    logic                  bit_end;
    logic                  last_data;

    fifo_uart_tx_bitcnt #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bitcnt (
        .clk         (CLK),
        .rst         (RST),
        .run         (state_q != ST_IDLE),
        .data_phase  (state_q == ST_DATA),
        .prescale    (presc_q),
        .bit_end_c   (bit_end),
        .last_data_c (last_data)
    );

    // Next-state, frame load and registered-output values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        presc_d   = presc_q;
        r_inc_d   = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!EMPTY) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!EMPTY) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture word and frame settings; settings stay fixed until the next load.
        if (load) begin
            shift_d   = RD_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = (^RD_DATA) ^ (PAR_TYP == PAR_ODD);
            presc_d   = PRESCALE;
            r_inc_d   = 1'b1;
            state_d   = ST_START;
        end

        busy_d = (state_d != ST_IDLE);

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= '0;
            tx_q      <= 1'b1;
            r_inc_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            presc_q   <= presc_d;
            tx_q      <= tx_d;
            r_inc_q   <= r_inc_d;
            busy_q    <= busy_d;
        end
    end

    assign R_INC  = r_inc_q;
    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule
